// File: rtl/data_sram_if_pkg.sv
// Shared encodings for the memory-stage sram-like data interface:
// access sizes, FSM states, lane-select widths and the alignment check.
package data_sram_if_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   localparam int LANE_BYTE_W = 8;
   localparam int LANE_HALF_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // True when the size encoding is illegal or the address is not naturally aligned.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = (addr_lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_sram_if_load_align.sv
// Combinational load lane select: shifts the addressed byte/halfword of the
// read word down to bit 0 and sign- or zero-extends it.
module data_sram_if_load_align
   import data_sram_if_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        load_sign,
   output logic [31:0] aligned
);

   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   logic [LANE_BYTE_W-1:0] lane_b;
   logic [LANE_HALF_W-1:0] lane_h;

   always_comb begin
      byte_shift = rdata >> {addr_lo, 3'b000};
      half_shift = rdata >> {addr_lo[1], 4'b0000};
      lane_b     = byte_shift[LANE_BYTE_W-1:0];
      lane_h     = half_shift[LANE_HALF_W-1:0];
      case (size)
         SIZE_BYTE: aligned = {{(32-LANE_BYTE_W){load_sign & lane_b[LANE_BYTE_W-1]}}, lane_b};
         SIZE_HALF: aligned = {{(32-LANE_HALF_W){load_sign & lane_h[LANE_HALF_W-1]}}, lane_h};
         default:   aligned = rdata;
      endcase
   end

endmodule

// File: rtl/data_sram_if.sv
// Memory-stage bridge to an sram-like data bus: issues one request per
// load/store, stalls the pipe until data_ok, and holds the aligned load result.
module data_sram_if
   import data_sram_if_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_en,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic        load_sign,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        pipe_hold,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        mem_stall,
   output logic [31:0] load_data,
   output logic        addr_err
);

   state_e      state_q, state_d;
   logic [31:0] load_data_q, load_data_d;
   logic [31:0] aligned;
   logic        access_ok;
   logic        req_c, stall_c, capture;

   data_sram_if_load_align u_load_align (
      .rdata     (data_rdata),
      .addr_lo   (mem_addr[1:0]),
      .size      (mem_size),
      .load_sign (load_sign),
      .aligned   (aligned)
   );

   assign addr_err  = mem_en & misaligned(mem_size, mem_addr[1:0]);
   assign access_ok = mem_en & ~addr_err;

   always_comb begin
      state_d     = state_q;
      req_c       = 1'b0;
      stall_c     = 1'b0;
      capture     = 1'b0;
      load_data_d = load_data_q;
      case (state_q)
         // IDLE with a valid access behaves exactly like REQ in the same cycle.
         ST_IDLE, ST_REQ: begin
            if (state_q == ST_REQ || access_ok) begin
               req_c   = 1'b1;
               stall_c = 1'b1;
               if (data_addr_ok && data_data_ok) begin
                  state_d = ST_DONE;
                  capture = 1'b1;
               end else if (data_addr_ok) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_WAIT: begin
            stall_c = 1'b1;
            if (data_data_ok) begin
               state_d = ST_DONE;
               capture = 1'b1;
            end
         end
         ST_DONE: begin
            if (!pipe_hold) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (capture && !mem_wr) load_data_d = aligned;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         load_data_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         load_data_q <= load_data_d;
      end
   end

   // Reset must silence the bus and the stall even while the pipe still presents an access.
   assign data_req  = req_c & rstn;
   assign mem_stall = stall_c & rstn;
   assign load_data = load_data_q;

   assign data_wr   = mem_wr;
   assign data_size = mem_size;
   assign data_addr = mem_addr;

   always_comb begin
      case (mem_size)
         SIZE_BYTE: data_wdata = {4{mem_wdata[7:0]}};
         SIZE_HALF: data_wdata = {2{mem_wdata[15:0]}};
         default:   data_wdata = mem_wdata;
      endcase
   end

endmodule

// File: tb/tb_data_sram_if.sv
// Self-checking bench for data_sram_if: directed vector table, reset-abort
// sequence, and randomized accesses against a cycle-count reference model.
module tb_data_sram_if;

   logic        clk = 1'b0;
   logic        rstn;
   logic        mem_en, mem_wr, load_sign, pipe_hold;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_stall, addr_err;
   logic [31:0] load_data;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_load = 32'd0;

   always #5 clk = ~clk;

   data_sram_if dut (
      .clk          (clk),
      .rstn         (rstn),
      .mem_en       (mem_en),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .load_sign    (load_sign),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .pipe_hold    (pipe_hold),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_stall    (mem_stall),
      .load_data    (load_data),
      .addr_err     (addr_err)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          a;        // cycle of addr_ok
      int          d;        // cycle of data_ok (>= a)
      int          hold;     // DONE cycles with pipe_hold=1
      logic        spurious; // data_ok pulses before addr_ok
      logic [31:0] rdata;
      logic        exp_err;
      logic [31:0] exp_load;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'd3) return 1'b1;
      if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
      if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [1:0] size, input logic sign);
      logic [7:0]  b [4];
      logic [15:0] h;
      int          idx;
      for (int i = 0; i < 4; i++) b[i] = 8'((rdata >> (8 * i)) & 32'hFF);
      idx = int'(addr % 4);
      if (size == 2'd0) begin
         if (sign && b[idx] >= 8'h80) return 32'hFFFFFF00 + 32'(b[idx]);
         return 32'(b[idx]);
      end else if (size == 2'd1) begin
         h = {b[(idx / 2) * 2 + 1], b[(idx / 2) * 2]};
         if (sign && h >= 16'h8000) return 32'hFFFF0000 + 32'(h);
         return 32'(h);
      end
      return rdata;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [1:0] size);
      if (size == 2'd0) return (w & 32'hFF) * 32'h01010101;
      if (size == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_access(input vec_t v, input int idx);
      mem_en    = 1'b1;
      mem_wr    = v.wr;
      mem_size  = v.size;
      load_sign = v.sign;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
      if (v.exp_err) begin
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
         @(negedge clk);
         check("err_flag", 32'(addr_err), 32'd1);
         check("err_req", 32'(data_req), 32'd0);
         check("err_stall", 32'(mem_stall), 32'd0);
         tick();
         mem_en = 1'b0;
         @(negedge clk);
         check("err_after_req", 32'(data_req), 32'd0);
         check("err_load_kept", load_data, last_load);
         tick();
         $display("txn %0d: addr=0x%08h size=%0d err", idx, v.addr, v.size);
         return;
      end
      for (int c = 0; c <= v.d + 1 + v.hold; c++) begin
         data_addr_ok = (c == v.a);
         data_data_ok = (c == v.d) || (v.spurious && c < v.a);
         data_rdata   = (c == v.d) ? v.rdata : $urandom;
         pipe_hold    = (c <= v.d) ? 1'($urandom_range(0, 1)) : (c <= v.d + v.hold);
         @(negedge clk);
         check("req", 32'(data_req), 32'(c <= v.a));
         check("stall", 32'(mem_stall), 32'(c <= v.d));
         check("addr_err", 32'(addr_err), 32'd0);
         if (c <= v.a) begin
            check("data_addr", data_addr, v.addr);
            check("data_size", 32'(data_size), 32'(v.size));
            check("data_wr", 32'(data_wr), 32'(v.wr));
            check("data_wdata", data_wdata, v.exp_wdata);
         end
         if (c > v.d) check("load_data", load_data, v.wr ? last_load : v.exp_load);
         tick();
      end
      mem_en       = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      pipe_hold    = 1'b0;
      if (!v.wr) last_load = v.exp_load;
      $display("txn %0d: %s addr=0x%08h size=%0d a=%0d d=%0d hold=%0d load=0x%08h",
               idx, v.wr ? "st" : "ld", v.addr, v.size, v.a, v.d, v.hold, load_data);
   endtask

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sign,
                               input logic [31:0] addr, input logic [31:0] wdata, input int a,
                               input int d, input int hold, input logic sp, input logic [31:0] rdata,
                               input logic err, input logic [31:0] eload, input logic [31:0] ewd);
      vec_t v;
      v.wr = wr; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
      v.a = a; v.d = d; v.hold = hold; v.spurious = sp; v.rdata = rdata;
      v.exp_err = err; v.exp_load = eload; v.exp_wdata = ewd;
      return v;
   endfunction

   initial begin
      vec_t rv;
      int   r;

      tbl[0]  = mk(0, 2'd2, 0, 32'h100, 32'h12345678, 1, 3, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h12345678);
      tbl[1]  = mk(0, 2'd0, 1, 32'h103, 32'h0,        0, 0, 0, 0, 32'h80FFFFFF, 0, 32'hFFFFFF80, 32'h0);
      tbl[2]  = mk(0, 2'd0, 0, 32'h103, 32'h0,        0, 0, 0, 0, 32'h80FFFFFF, 0, 32'h00000080, 32'h0);
      tbl[3]  = mk(1, 2'd1, 0, 32'h202, 32'h0000ABCD, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'hABCDABCD);
      tbl[4]  = mk(0, 2'd2, 0, 32'h102, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,        32'h0);
      tbl[5]  = mk(0, 2'd2, 0, 32'h104, 32'h0,        0, 2, 3, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 32'h0);
      tbl[6]  = mk(0, 2'd1, 1, 32'h106, 32'h0,        2, 2, 1, 1, 32'h80011234, 0, 32'hFFFF8001, 32'h0);
      tbl[7]  = mk(0, 2'd3, 0, 32'h108, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,        32'h0);
      tbl[8]  = mk(1, 2'd1, 0, 32'h201, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,        32'h0);
      tbl[9]  = mk(1, 2'd0, 0, 32'h300, 32'h000000A5, 1, 1, 0, 0, 32'h0,        0, 32'h0,        32'hA5A5A5A5);
      tbl[10] = mk(0, 2'd0, 0, 32'h101, 32'h0,        0, 1, 2, 0, 32'h11223344, 0, 32'h00000033, 32'h0);

      // Reset held with an access presented: bus and stall must stay quiet.
      rstn = 1'b0; mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; load_sign = 1'b0;
      mem_addr = 32'h100; mem_wdata = 32'h0; pipe_hold = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      @(negedge clk);
      check("rst_req", 32'(data_req), 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_load", load_data, 32'd0);
      tick();
      mem_en = 1'b0;
      rstn   = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) run_access(tbl[i], i);

      // Reset while in WAIT, then a stale data_ok must be ignored.
      mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h100;
      data_addr_ok = 1'b1; data_data_ok = 1'b0;
      @(negedge clk);
      check("abort_req0", 32'(data_req), 32'd1);
      tick();
      data_addr_ok = 1'b0;
      @(negedge clk);
      check("abort_wait_req", 32'(data_req), 32'd0);
      check("abort_wait_stall", 32'(mem_stall), 32'd1);
      #1 rstn = 1'b0;
      #1;
      check("abort_rst_stall", 32'(mem_stall), 32'd0);
      check("abort_rst_load", load_data, 32'd0);
      tick();
      rstn = 1'b1; mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      check("stale_req", 32'(data_req), 32'd0);
      check("stale_stall", 32'(mem_stall), 32'd0);
      tick();
      data_data_ok = 1'b0;
      @(negedge clk);
      check("stale_load", load_data, 32'd0);
      last_load = 32'd0;
      mem_en = 1'b1; mem_addr = 32'h108; data_data_ok = 1'b1;
      @(negedge clk);
      check("post_rst_req", 32'(data_req), 32'd1);
      tick();
      data_data_ok = 1'b0;
      @(negedge clk);
      check("post_rst_still_req", 32'(data_req), 32'd1);
      check("post_rst_stall", 32'(mem_stall), 32'd1);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h55AA55AA;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      check("post_rst_done_stall", 32'(mem_stall), 32'd0);
      check("post_rst_load", load_data, 32'h55AA55AA);
      tick();
      mem_en = 1'b0;
      last_load = 32'h55AA55AA;
      $display("txn abort: reset in WAIT, stale data_ok ignored, load=0x%08h", load_data);

      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(0, 15));
         rv.wr    = 1'($urandom_range(0, 1));
         rv.size  = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rv.sign  = 1'($urandom_range(0, 1));
         rv.addr  = $urandom;
         if (r > 2) rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
         rv.wdata = $urandom;
         rv.a     = int'($urandom_range(0, 3));
         rv.d     = rv.a + int'($urandom_range(0, 3));
         rv.hold  = int'($urandom_range(0, 3));
         rv.spurious = 1'($urandom_range(0, 1));
         rv.rdata = $urandom;
         rv.exp_err   = model_err(rv.size, rv.addr);
         rv.exp_load  = model_load(rv.rdata, rv.addr, rv.size, rv.sign);
         rv.exp_wdata = model_wdata(rv.wdata, rv.size);
         run_access(rv, 100 + i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
